// File: rtl/tdp_ram.sv
// Purpose: true dual-port synchronous RAM with byte enables, collision detect/count and optional post-reset clear engine (DPRAM_CLEAR_EN).
// Latency: 1 cycle read (dout_x/valid_x and collision registered).
// Backpressure: none; ports are ignored only while busy (clear engine running).
module tdp_ram #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [DATA_W/8-1:0]   be_a,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [DATA_W-1:0]     din_a,
    output logic [DATA_W-1:0]     dout_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [DATA_W/8-1:0]   be_b,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_W-1:0]     din_b,
    output logic [DATA_W-1:0]     dout_b,
    output logic                  valid_b,
    output logic                  busy,
    output logic                  collision,
    output logic [15:0]           coll_cnt
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              acc_a, acc_b, wr_a, wr_b, same_addr;
    logic [DATA_W-1:0] old_a, old_b, stored_a, stored_b;

    logic [DATA_W-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
    logic              valid_a_q, valid_a_d, valid_b_q, valid_b_d;
    logic              coll_q, coll_d;
    logic [15:0]       cnt_q, cnt_d;

`ifdef DPRAM_CLEAR_EN
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // Clear engine: zero one word per cycle, then run until the next reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == {ADDR_W{1'b1}}) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    // Clear FSM state and pointer; reset restarts the walk from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy     = (state_q == S_CLEAR);
    assign clr_addr = ptr_q;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign acc_a     = en_a & ~busy;
    assign acc_b     = en_b & ~busy;
    assign wr_a      = acc_a & we_a;
    assign wr_b      = acc_b & we_b;
    assign same_addr = (addr_a == addr_b);
    assign old_a     = mem_q[addr_a];
    assign old_b     = mem_q[addr_b];

    // Word as it will be stored at each port's address: byte merge with port A priority.
    always_comb begin
        stored_a = old_a;
        stored_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (wr_a && be_a[i])
                stored_a[i*8 +: 8] = din_a[i*8 +: 8];
            else if (wr_b && same_addr && be_b[i])
                stored_a[i*8 +: 8] = din_b[i*8 +: 8];
            if (wr_a && same_addr && be_a[i])
                stored_b[i*8 +: 8] = din_a[i*8 +: 8];
            else if (wr_b && be_b[i])
                stored_b[i*8 +: 8] = din_b[i*8 +: 8];
        end
    end

    // Memory array: both merged words are identical on a shared address, so two writes are safe.
    always_ff @(posedge clk) begin
        if (clr_we) mem_q[clr_addr] <= '0;
        if (wr_a)   mem_q[addr_a]   <= stored_a;
        if (wr_b)   mem_q[addr_b]   <= stored_b;
    end

    // Read data, valid strobes and collision accounting for the next cycle.
    always_comb begin
        dout_a_d  = dout_a_q;
        dout_b_d  = dout_b_q;
        valid_a_d = acc_a;
        valid_b_d = acc_b;
        if (acc_a) dout_a_d = (RDW_MODE == 1 && wr_a) ? stored_a : old_a;
        if (acc_b) dout_b_d = (RDW_MODE == 1 && wr_b) ? stored_b : old_b;
        coll_d = acc_a & acc_b & same_addr & (we_a | we_b);
        cnt_d  = cnt_q;
        if (coll_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a_q  <= '0;
            dout_b_q  <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            coll_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            dout_a_q  <= dout_a_d;
            dout_b_q  <= dout_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
            coll_q    <= coll_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dout_a    = dout_a_q;
    assign dout_b    = dout_b_q;
    assign valid_a   = valid_a_q;
    assign valid_b   = valid_b_q;
    assign collision = coll_q;
    assign coll_cnt  = cnt_q;
endmodule

// File: doc/tdp_ram.md
# tdp_ram

Parametrised true dual-port synchronous RAM; successor to the fixed 256×32 dual-port RAM. Two symmetric ports, each able to read or write any address every cycle, with byte enables, registered read data and a valid strobe. Defined same-address collision resolution, a saturating collision counter and an optional post-reset clear engine. Used as shared scratch/buffer memory between two masters in the same clock domain.

## Interface
Parameters:
- DATA_W, 32, word width in bits; multiple of 8
- ADDR_W, 8, address width; depth = 2^ADDR_W words
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en_a  in  1  port A access enable
- we_a  in  1  port A write (valid only with en_a)
- be_a  in  DATA_W/8  port A byte enables for writes
- addr_a  in  ADDR_W  port A address
- din_a  in  DATA_W  port A write data
- dout_a  out  DATA_W  port A registered read data
- valid_a  out  1  dout_a updated this cycle
- en_b, we_b, be_b, addr_b, din_b, dout_b, valid_b: port B, identical to A
- busy  out  1  clear engine active; ports ignored
- collision  out  1  one-cycle pulse: same-address access on both ports with at least one write
- coll_cnt  out  16  saturating collision count

## Operation
- Every cycle with en_x=1 (and busy=0): memory read at addr_x; if we_x=1, bytes i with be_x[i]=1 take din_x byte i. Other bytes unchanged.
- Every enabled access (read or write) updates dout_x and pulses valid_x next cycle.
- Same-port write: dout_x = old word (RDW_MODE=0) or word as stored at end of cycle (RDW_MODE=1, includes merge with other port).
- Cross-port read/write to same address: reader always gets old word.
- Write/write same address: per-byte merge, port A priority; a byte takes din_b only where be_a[i]=0 and be_b[i]=1.
- collision asserts when en_a&en_b&(addr_a==addr_b)&(we_a|we_b); coll_cnt increments, saturates at 16'hFFFF. Read/read to same address is not a collision.
- State machine: CLEAR (present only with DPRAM_CLEAR_EN) -> RUN. CLEAR walks an internal pointer 0..2^ADDR_W-1 writing zero, one word per cycle, then enters RUN. RUN is terminal until rst.
- be_x=0 with we_x=1: no memory change, still a read with valid_x.

## Timing
- Read latency: 1 cycle (request at edge N, dout_x/valid_x valid after edge N+1).
- Reset values: dout_a=dout_b=0, valid_a=valid_b=0, collision=0, coll_cnt=0; busy=1 on the cycle after rst with clear enabled, else 0.
- Clear duration: exactly 2^ADDR_W cycles after rst deasserts; busy falls on the cycle the last word is written; first accepted access the cycle after busy=0.
- During busy: en_x/we_x ignored, valid_x=0, dout_x held at 0, no collision counting.
- rst asserted mid-clear: pointer restarts at 0, full clear repeats.
- rst does not clear memory contents itself (only the clear engine does).
- collision is a registered pulse, aligned with valid_x of the colliding access.

## Configuration
- DPRAM_CLEAR_EN defined: CLEAR state and pointer compiled in; after every reset memory is all-zero before busy falls.
- Not defined: no clear engine; busy tied 0; FSM starts in RUN; memory contents after reset undefined (X in simulation); ports accept accesses the first cycle after rst deasserts.

## Test plan
- Reset with DPRAM_CLEAR_EN, ADDR_W=8: busy high 256 cycles; then read A at 8'h7F -> dout_a=0, valid_a=1 one cycle later.
- A writes 32'hA5A5A5A5 to 8'h01 (be=4'hF); next cycle B reads 8'h01 -> dout_b=32'hA5A5A5A5 after 1 cycle.
- Same cycle A writes 32'h11111111 be=4'h3, B writes 32'h22222222 be=4'hF to 8'h10 -> stored 32'h22221111; collision pulse; coll_cnt=1.
- RDW_MODE=0 vs 1: address 8'h05 holds 32'hDEADBEEF, A writes 32'h12345678 -> dout_a 32'hDEADBEEF vs 32'h12345678.
- B reads 8'h20 while A writes 8'h20 -> dout_b = old value, collision=1; read/read 8'h20 both ports -> collision=0.
- Force 65536 collisions -> coll_cnt stays 16'hFFFF; rst mid-clear at pointer 100 -> busy lasts 256 further cycles.
